// File: rtl/shifter_pkg.sv
// Shared op encoding and helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam int OP_W = 3;

  // Shift/rotate modes; encodings 5..7 pass the operand through untouched.
  typedef enum logic [OP_W-1:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_e;

  localparam logic [OP_W-1:0] OP_LAST_SHIFT = 3'd4;

  // True when the op actually moves bits (anything above ROR is pass-through).
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return op <= OP_LAST_SHIFT;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One binary stage of the barrel shifter: conditional 2^K shift/rotate
// followed by a pipeline register with valid/ready handshake.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int K     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [OP_W-1:0]          in_op,
  input  logic                     in_sign,
  input  logic                     next_ready,
  output logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(WIDTH)-1:0] amt,
  output logic [OP_W-1:0]          op,
  output logic                     sign
);

  localparam int SH = 1 << K;
  // Upper SH bits set: where SRA drops copies of the original sign.
  localparam logic [WIDTH-1:0] FILL = ~({WIDTH{1'b1}} >> SH);

  logic [WIDTH-1:0] shifted;

  // Apply this stage's 2^K step only when its amount bit is set.
  always_comb begin
    shifted = in_data;
    if (in_amt[K] && is_shift_op(in_op)) begin
      case (in_op)
        OP_SLL:  shifted = in_data << SH;
        OP_SRL:  shifted = in_data >> SH;
        OP_SRA:  shifted = (in_data >> SH) | (in_sign ? FILL : '0);
        OP_ROL:  shifted = (in_data << SH) | (in_data >> (WIDTH - SH));
        OP_ROR:  shifted = (in_data >> SH) | (in_data << (WIDTH - SH));
        default: shifted = in_data;
      endcase
    end
  end

  // A stage can take a new item when empty or when its item moves on.
  assign ready = ~valid | next_ready;

  // Pipeline register; payload only refreshed by real items so a held
  // result stays put and bubbles never disturb it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      op    <= '0;
      sign  <= 1'b0;
    end else if (ready) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= shifted;
        amt  <= in_amt;
        op   <= in_op;
        sign <= in_sign;
      end
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Parametrised pipelined barrel shifter: SAW binary stages, one per
// shift-amount bit, chained with an elastic valid/ready handshake.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SAW-1:0]   in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int S = SAW;

  // Per-stage inputs (src_*) and registered outputs.
  logic [S-1:0]            src_valid, valid, sign, src_sign;
  logic [S-1:0][WIDTH-1:0] src_data, data;
  logic [S-1:0][SAW-1:0]   src_amt, amt;
  logic [S-1:0][OP_W-1:0]  src_op, op;
  logic [S:0]              rdy;

  assign rdy[S]    = out_ready;
  assign in_ready  = rdy[0];
  assign out_valid = valid[S-1];
  assign out_data  = data[S-1];

  genvar k;
  generate
    for (k = 0; k < S; k++) begin : g_stage
      if (k == 0) begin : g_head
        // Sign is captured from the original operand and carried along.
        assign src_valid[k] = in_valid;
        assign src_data[k]  = in_data;
        assign src_amt[k]   = in_amt;
        assign src_op[k]    = in_op;
        assign src_sign[k]  = in_data[WIDTH-1];
      end else begin : g_link
        assign src_valid[k] = valid[k-1];
        assign src_data[k]  = data[k-1];
        assign src_amt[k]   = amt[k-1];
        assign src_op[k]    = op[k-1];
        assign src_sign[k]  = sign[k-1];
      end

      shifter_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (src_valid[k]),
        .in_data    (src_data[k]),
        .in_amt     (src_amt[k]),
        .in_op      (src_op[k]),
        .in_sign    (src_sign[k]),
        .next_ready (rdy[k+1]),
        .ready      (rdy[k]),
        .valid      (valid[k]),
        .data       (data[k]),
        .amt        (amt[k]),
        .op         (op[k]),
        .sign       (sign[k])
      );
    end
  endgenerate

  // The last stage's control fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt[S-1], op[S-1], sign[S-1]};

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe (WIDTH=32): vectors, latency,
// backpressure, reset flush, and a short randomised run against a model.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_assert = 0;
  int n_fail   = 0;

  shifter_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference, written independently of the staged structure.
  function automatic logic [31:0] ref_shift(input logic [2:0] o, input int a, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (o)
        3'd0:    r[i] = (i >= a) ? d[i-a] : 1'b0;
        3'd1:    r[i] = (i + a < 32) ? d[i+a] : 1'b0;
        3'd2:    r[i] = (i + a < 32) ? d[i+a] : d[31];
        3'd3:    r[i] = d[(i - a + 32) % 32];
        3'd4:    r[i] = d[(i + a) % 32];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // One isolated item: checks exact 5-stage latency and the result.
  task automatic run_one(input string tag, input logic [2:0] o, input int a,
                         input logic [31:0] d, input logic [31:0] e);
    logic [31:0] av;
    av = a;
    @(negedge clk);
    in_valid = 1'b1; in_op = o; in_amt = av[4:0]; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, {32'd0, out_data}, {32'd0, e});
  endtask

  function automatic logic [31:0] stall_item(input int i);
    return 32'h1000_0000 | i;
  endfunction

  initial begin
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int   got_cyc[$];
    int   sent, got, cyc;
    bit   go, stale;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;

    // Directed vectors
    run_one("sll_1_2",      3'd0, 2,  32'h0000_0001, 32'h0000_0004);
    run_one("srl_msb_31",   3'd1, 31, 32'h8000_0000, 32'h0000_0001);
    run_one("sra_neg_4",    3'd2, 4,  32'h8000_0000, 32'hF800_0000);
    run_one("sra_pos_4",    3'd2, 4,  32'h7000_0000, 32'h0700_0000);
    run_one("ror_1_1",      3'd4, 1,  32'h0000_0001, 32'h8000_0000);
    run_one("rol_4",        3'd3, 4,  32'h8000_0001, 32'h0000_0018);
    run_one("sra_neg_31",   3'd2, 31, 32'h8000_0000, 32'hFFFF_FFFF);
    run_one("rol_8",        3'd3, 8,  32'h1234_5678, 32'h3456_7812);
    run_one("sll_ones_31",  3'd0, 31, 32'hFFFF_FFFF, 32'h8000_0000);
    run_one("ror_13",       3'd4, 13, 32'h0000_2000, 32'h0000_0001);
    run_one("amt0_sll",     3'd0, 0,  32'hA5C3_0F96, 32'hA5C3_0F96);
    run_one("amt0_srl",     3'd1, 0,  32'hA5C3_0F96, 32'hA5C3_0F96);
    run_one("amt0_sra",     3'd2, 0,  32'hA5C3_0F96, 32'hA5C3_0F96);
    run_one("amt0_rol",     3'd3, 0,  32'hA5C3_0F96, 32'hA5C3_0F96);
    run_one("amt0_ror",     3'd4, 0,  32'hA5C3_0F96, 32'hA5C3_0F96);
    run_one("op6_pass",     3'd6, 7,  32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Backpressure: 10 items ROL 4, consumer stalled for 10 cycles.
    sent = 0; got = 0; cyc = 0;
    in_op = 3'd3; in_amt = 5'd4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = (sent < 10); in_data = stall_item(sent);
      #1;
      go = in_valid && in_ready;
      @(posedge clk);
      if (go) sent++;
    end
    @(negedge clk);
    chk("stall_accepted", sent, 5);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    chk("stall_hold_item0", {32'd0, out_data}, 64'h0000_0001);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = (sent < 10); in_data = stall_item(sent);
      #1;
      go = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(c);
        got++;
      end
      @(posedge clk);
      if (go) sent++;
    end
    chk("drain_count", got, 10);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("drain_item%0d", i), {32'd0, got_q[i]}, {32'd0, 32'h1 | (i << 4)});
    if (got_cyc.size() == 10)
      chk("drain_back_to_back", got_cyc[9] - got_cyc[0], 9);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset with 3 items in flight; reset beats the simultaneous handshake.
    out_ready = 1'b0;
    in_op = 3'd0; in_amt = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h100 + i;
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_out_data", {32'd0, out_data}, 64'd0);
    reset = 1'b1; in_valid = 1'b0;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("flush_no_stale", {63'd0, stale}, 64'd0);

    // Randomised traffic with random stalls against the reference model.
    sent = 0; got = 0;
    exp_q.delete();
    for (int c = 0; c < 5000 && got < 400; c++) begin
      @(negedge clk);
      in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_amt    = 5'($urandom_range(0, 31));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      go = in_valid && in_ready;
      if (go) exp_q.push_back(ref_shift(in_op, int'(in_amt), in_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand_spurious", {63'd0, out_valid}, 64'd0);
        else chk($sformatf("rand_item%0d", got), {32'd0, out_data}, {32'd0, exp_q.pop_front()});
        got++;
      end
      @(posedge clk);
      if (go) sent++;
    end
    chk("rand_count", got, 400);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter, successor to the fixed 32-bit shift-by-2 block of the 32-bit shifter set. It shifts or rotates a WIDTH-bit operand by a run-time amount in one of five modes. One binary stage is registered per amount bit, with a valid/ready handshake on both sides. It sits between the operand source and the result consumer and sustains one result per cycle under full backpressure support.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 4
- SAW, $clog2(WIDTH), shift-amount width and number of pipeline stages S
- clk  in  1  clock, all state updates on posedge
- reset  in  1  reset, synchronous, active-low
- in_valid  in  1  operand/op/amount valid
- in_ready  out  1  block can accept this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SAW  shift amount, 0..WIDTH-1
- in_op  in  3  mode: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 pass-through
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result

## Operation
- S = SAW stages. Stage k holds valid_k, data_k, amt, op, and sign (bit WIDTH-1 of the original operand).
- Stage k applies a shift of 2^k to its incoming data when amt[k]=1, otherwise passes the data unchanged.
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill from the MSB with the carried sign bit.
  - ROL/ROR: bits wrap around.
  - Ops 5–7: data unchanged at every stage.
- Stage 0 processes in_data combinationally into its register. Stage k>0 processes data_{k-1}.
- Ready chain: ready_k = ~valid_k | ready_{k+1}, with ready_S = out_ready. Stage k loads when ready_k. It loads valid from the previous stage, or in_valid for stage 0. in_ready = ready_0.
- A transfer occurs when valid & ready on the same edge. A stage not loading holds all of its fields.
- out_valid = valid_{S-1}; out_data = data_{S-1}.
- Results leave in acceptance order. No drop, no duplication.
- Shift by 0 returns the operand unchanged in every mode.
- Result is independent of the downstream stall pattern.

## Timing
- Reset (reset=0 at posedge): every valid_k clears to 0. Data fields are don't-care and are also cleared to 0.
  - Next cycle: out_valid=0, out_data=0, in_ready=1.
- Reset mid-operation: all in-flight items are discarded. No output follows.
- Reset has priority over any simultaneous handshake.
- Latency: an item accepted at edge N appears at the output in the cycle after edge N+S-1, i.e. S register stages. For WIDTH=32, S=5.
- Throughput: 1 item per cycle while out_ready=1. A full pipe with out_ready=1 accepts and emits on the same edge.
- Stall: while out_valid=1 and out_ready=0, out_data stays stable. Upstream stages keep filling until all S are valid, then in_ready=0.
- in_ready depends combinationally on out_ready through the chain. No combinational path exists from in_* to out_*.

## Structure
- Package shifter_pkg:
  - shift_op_e enum: SLL, SRL, SRA, ROL, ROR.
  - Localparam helpers for the op encoding.
- Sub-module shifter_stage, parameters WIDTH and K:
  - Combinational 2^K shift/rotate per op.
  - Pipeline register with the valid/ready handshake.
- shifter_pipe instantiates S copies in a generate loop.

## Test plan
- SLL 0x00000001 by 2, out_ready=1 → 0x00000004 after 5 cycles. SRL 0x80000000 by 31 → 0x00000001.
- SRA 0x80000000 by 4 → 0xF8000000. SRA 0x70000000 by 4 → 0x07000000.
- ROR 0x00000001 by 1 → 0x80000000. ROL 0x80000001 by 4 → 0x00000018. Amount 0 in all modes → operand unchanged. Op 6 → operand unchanged.
- Continuous input of 10 items, out_ready=0 for 10 cycles:
  - in_ready drops after 5 accepted; out_data holds item 0.
  - After out_ready returns to 1, all 10 results arrive in order, one per cycle.
- Reset asserted with 3 items in flight → next cycle out_valid=0, in_ready=1. No stale result ever emerges.
- Random op/amount/data, random in_valid/out_ready, 65536 items vs reference model → 0 mismatches, counts equal. Repeat with WIDTH=8 and WIDTH=64.
